inst_mem_arbiter: RTL and testbench

INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

---
 rtl/inst_mem_arb_pkg.sv | 17 +
 rtl/inst_mem_arbiter_rr_arb2.sv | 62 ++++++
 rtl/inst_mem_arbiter.sv | 95 +++++++++
 tb/tb_inst_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths and
// the master identifiers used for grant bookkeeping.
package inst_mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_LDR = 1'b1
  } mst_e;

  // Bit positions of each master inside request/grant vectors.
  localparam int IDX_CPU = 0;
  localparam int IDX_LDR = 1;

endpackage

// File: rtl/inst_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a loader lock: the loader can claim
// exclusive ownership and keep the CPU out until it drops its lock request.
module rr_arb2
  import inst_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] grant
);

  mst_e last_q;
  mst_e last_d;
  logic lock_own_q;
  logic lock_own_d;
  logic cpu_req;
  logic ldr_req;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant      = '0;
    last_d     = last_q;
    lock_own_d = lock_own_q;

    cpu_req = req[IDX_CPU] & ~(lock_own_q & lock);
    ldr_req = req[IDX_LDR];

    if (cpu_req && ldr_req) begin
      if (last_q == MST_LDR) grant[IDX_CPU] = 1'b1;
      else                   grant[IDX_LDR] = 1'b1;
    end else if (cpu_req) begin
      grant[IDX_CPU] = 1'b1;
    end else if (ldr_req) begin
      grant[IDX_LDR] = 1'b1;
    end

    if (grant[IDX_CPU])      last_d = MST_CPU;
    else if (grant[IDX_LDR]) last_d = MST_LDR;

    // Ownership is released by any cycle with the lock request low.
    if (!lock)                lock_own_d = 1'b0;
    else if (grant[IDX_LDR])  lock_own_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Loader counts as last winner so the CPU takes the first tie.
      last_q     <= MST_LDR;
      lock_own_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      last_q     <= last_d;
      lock_own_q <= lock_own_d;
    end
  end

  grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
  lock_denies_cpu: assert property (@(posedge clk) disable iff (!reset_n)
    (lock_own_q && lock) |-> !grant[IDX_CPU]);

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one single-port instruction RAM between the CPU fetch port (read-only)
// and the NoC program loader; tracks one-cycle read latency per master.
module inst_mem_arbiter
  import inst_mem_arb_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       m0_rdv_q;
  logic       m1_rdv_q;

  // Requests are masked while reset is held so the RAM sees nothing and both
  // masters are stalled.
  assign req = {m1_read | m1_write, m0_read} & {2{reset_n}};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lock    (m1_lock),
    .grant   (grant)
  );

  assign m0_waitrequest = ~grant[IDX_CPU];
  assign m1_waitrequest = ~grant[IDX_LDR];

  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant[IDX_CPU]) begin
      mem_address    = m0_address;
      mem_chipselect = 1'b1;
      mem_byteenable = '1;
    end else if (grant[IDX_LDR]) begin
      mem_address    = m1_address;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_byteenable;
    end
  end

  // One-deep valid tracker per master; a loader read+write counts as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rdv_q <= 1'b0;
      m1_rdv_q <= 1'b0;
    end else begin
      m0_rdv_q <= grant[IDX_CPU];
      m1_rdv_q <= grant[IDX_LDR] & m1_read & ~m1_write;
    end
  end

  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  rdv_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_readdatavalid && m1_readdatavalid));

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench: drives per-cycle stimulus with hand-derived grant
// expectations and scoreboards read data against a behavioural RAM.
module tb_inst_mem_arbiter;
  import inst_mem_arb_pkg::*;

  localparam int AW     = ADDR_W_DEF;
  localparam int DW     = DATA_W_DEF;
  localparam int BW     = DW / 8;
  localparam int G_NONE = 0;
  localparam int G_M0   = 1;
  localparam int G_M1   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0;
  logic          m0_read = 1'b0;
  logic          m0_waitrequest;
  logic [DW-1:0] m0_readdata;
  logic          m0_readdatavalid;
  logic [AW-1:0] m1_address = '0;
  logic          m1_read = 1'b0;
  logic          m1_write = 1'b0;
  logic [DW-1:0] m1_writedata = '0;
  logic [BW-1:0] m1_byteenable = '0;
  logic          m1_lock = 1'b0;
  logic          m1_waitrequest;
  logic [DW-1:0] m1_readdata;
  logic          m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_readdata;

  always #5 clk = ~clk;

  inst_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_lock          (m1_lock),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_readdata     (mem_readdata)
  );

  // Single-port RAM with one-cycle read latency and byte enables.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_q;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_address = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;
    m1_writedata = '0; m1_byteenable = '0; m1_lock = 1'b0;
  endtask

  // Drive one cycle of requests, check the combinational response against the
  // expected grant g, and queue the data any granted read must return.
  task automatic drive_cycle(input string tag,
                             input logic r0, input logic [AW-1:0] a0,
                             input logic r1, input logic w1, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d1, input logic [BW-1:0] be1,
                             input logic l1, input int g);
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic          e_wr;
    @(negedge clk);
    m0_read = r0; m0_address = a0;
    m1_read = r1; m1_write = w1; m1_address = a1;
    m1_writedata = d1; m1_byteenable = be1; m1_lock = l1;
    #1;
    e_addr = (g == G_M0) ? a0 : (g == G_M1) ? a1 : '0;
    e_be   = (g == G_M0) ? '1 : (g == G_M1) ? be1 : '0;
    e_wr   = (g == G_M1) ? w1 : 1'b0;
    check({tag, ".wait0"}, m0_waitrequest, g != G_M0);
    check({tag, ".wait1"}, m1_waitrequest, g != G_M1);
    check({tag, ".cs"},    mem_chipselect, g != G_NONE);
    check({tag, ".addr"},  mem_address, e_addr);
    check({tag, ".be"},    mem_byteenable, e_be);
    check({tag, ".wr"},    mem_write, e_wr);
    if (g != G_M0) check({tag, ".wdata"}, mem_writedata, (g == G_M1) ? d1 : '0);
    if (g == G_M0) q0.push_back(ram[a0]);
    if (g == G_M1 && r1 && !w1) q1.push_back(ram[a1]);
  endtask

  // Read-data scoreboard: every valid pulse must match the oldest queued read.
  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) check("m0_rdv_unexpected", 1, 0);
      else                check("m0_rdata", m0_readdata, q0.pop_front());
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) check("m1_rdv_unexpected", 1, 0);
      else                check("m1_rdata", m1_readdata, q1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hC0DE_0000 | i;
    ram[12'h010] = 32'h1234_5678;

    // Held in reset with both masters requesting: everything stalled and quiet.
    drive_cycle("rst", 1, 12'h010, 1, 0, 12'h020, '0, 4'hF, 0, G_NONE);
    check("rst.rdv0", m0_readdatavalid, 0);
    check("rst.rdv1", m1_readdatavalid, 0);
    idle_inputs();
    reset_n = 1'b1;
    drive_cycle("idle", 0, '0, 0, 0, '0, '0, '0, 0, G_NONE);

    // First tie after reset goes to the CPU; loader write follows next cycle.
    drive_cycle("tie0", 1, 12'h001, 0, 1, 12'h002, 32'hDEAD_BEEF, 4'hF, 0, G_M0);
    drive_cycle("tie1", 0, 12'h001, 0, 1, 12'h002, 32'hDEAD_BEEF, 4'hF, 0, G_M1);

    drive_cycle("m0rd", 1, 12'h010, 0, 0, '0, '0, '0, 0, G_M0);
    drive_cycle("m0rd_idle", 0, '0, 0, 0, '0, '0, '0, 0, G_NONE);
    drive_cycle("m1rb", 0, '0, 1, 0, 12'h002, '0, 4'hF, 0, G_M1);
    check("ram_002", ram[12'h002], 32'hDEAD_BEEF);

    // Continuous contention: strict alternation starting with the CPU.
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle("rr", 1, AW'(12'h030 + i), 1, 0, AW'(12'h040 + i), '0, 4'hF, 0,
                  (i % 2 == 0) ? G_M0 : G_M1);
      if (!m0_waitrequest) c0++;
      if (!m1_waitrequest) c1++;
    end
    check("rr_m0_count", c0, 4);
    check("rr_m1_count", c1, 4);

    // Back-to-back reads from a single master.
    for (int i = 0; i < 3; i++)
      drive_cycle("b2b0", 1, AW'(12'h050 + i), 0, 0, '0, '0, '0, 0, G_M0);
    for (int i = 0; i < 3; i++)
      drive_cycle("b2b1", 0, '0, 1, 0, AW'(12'h058 + i), '0, 4'hF, 0, G_M1);

    // Locked burst: CPU wins the opening tie, then four uninterrupted writes.
    drive_cycle("lk_a", 1, 12'h060, 0, 1, 12'h100, 32'h1000_0000, 4'hF, 1, G_M0);
    for (int i = 0; i < 4; i++)
      drive_cycle("lk_w", 1, 12'h060, 0, 1, AW'(12'h100 + i), 32'h1000_0000 + i, 4'hF, 1, G_M1);
    drive_cycle("lk_hold", 1, 12'h061, 0, 0, '0, '0, '0, 1, G_NONE);
    drive_cycle("lk_rel", 1, 12'h061, 0, 0, '0, '0, '0, 0, G_M0);
    for (int i = 0; i < 4; i++)
      check("lk_ram", ram[12'h100 + i], 32'h1000_0000 + i);

    // Partial byte write, then read+write treated as a plain write.
    drive_cycle("bytew", 0, '0, 0, 1, 12'h020, 32'h0000_AB00, 4'b0010, 0, G_M1);
    drive_cycle("rdwr", 0, '0, 1, 1, 12'h021, 32'h0000_0055, 4'hF, 0, G_M1);
    drive_cycle("bytew_rb", 0, '0, 1, 0, 12'h020, '0, 4'hF, 0, G_M1);
    check("ram_020", ram[12'h020], 32'hC0DE_AB20);
    check("ram_021", ram[12'h021], 32'h0000_0055);

    // Reset lands while a loader read is in flight: its valid must never appear.
    drive_cycle("rst_rd", 0, '0, 1, 0, 12'h030, '0, 4'hF, 0, G_M1);
    #1;
    reset_n = 1'b0;
    q1.delete();
    #1;
    check("rst2.wait0", m0_waitrequest, 1);
    check("rst2.wait1", m1_waitrequest, 1);
    check("rst2.cs", mem_chipselect, 0);
    idle_inputs();
    @(posedge clk); #1;
    check("rst2.rdv1", m1_readdatavalid, 0);
    check("rst2.rdv0", m0_readdatavalid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive_cycle("rst2_idle", 0, '0, 0, 0, '0, '0, '0, 0, G_NONE);
    check("rst2.rdv1_post", m1_readdatavalid, 0);
    drive_cycle("rst2_tie", 1, 12'h070, 1, 0, 12'h071, '0, 4'hF, 0, G_M0);

    drive_cycle("drain", 0, '0, 0, 0, '0, '0, '0, 0, G_NONE);
    drive_cycle("drain", 0, '0, 0, 0, '0, '0, '0, 0, G_NONE);
    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
